exc_sequencer: RTL

Multi-cycle exception/interrupt sequencer beside the processor controller. Takes the controller's exception request (exc, estatus) and ERET indication, plus the raw external interrupt line. Sequences pipeline flush, vector redirect, handler residency and return. Owns the exception registers (ELR, ESR) and drives the controller's exc_ack and the device's four-phase interrupt acknowledge.

---
 rtl/exc_pkg.sv | 22 ++
 rtl/exc_sequencer_if.sv | 38 +++
 rtl/irq_handshake.sv | 31 +++
 rtl/exc_sequencer.sv | 123 ++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared types and constants for the exception/interrupt sequencer.
package exc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FLUSH     = 3'd1,
        ST_VECTOR    = 3'd2,
        ST_HANDLER   = 3'd3,
        ST_RETURN    = 3'd4,
        ST_IACK_WAIT = 3'd5
    } exc_state_t;

    localparam int ES_W = 4;

    localparam logic [ES_W-1:0] ES_NONE    = 4'b0000;
    localparam logic [ES_W-1:0] ES_EXTIRQ  = 4'b0001;
    localparam logic [ES_W-1:0] ES_INVOP   = 4'b0010;
    localparam logic [ES_W-1:0] ES_UNALIGN = 4'b0100;

    localparam logic [63:0] VEC_ADDR_DFLT = 64'h00000000000000D8;

endpackage

// File: rtl/exc_sequencer_if.sv
// Controller/device-facing signal bundle of the exception sequencer.
// master = controller and device side, slave = the sequencer.
interface exc_sequencer_if #(
    parameter int N = 64
);
    import exc_pkg::*;

    logic            exc;
    logic [ES_W-1:0] estatus;
    logic            eret;
    logic [N-1:0]    pc_exc;
    logic            ext_irq;

    logic            irq_to_ctrl;
    logic            exc_ack;
    logic            ext_iack;
    logic            flush;
    logic            pc_sel_vec;
    logic            pc_sel_elr;
    logic [N-1:0]    vec_addr;
    logic [N-1:0]    elr_q;
    logic [ES_W-1:0] esr_q;
    logic            in_handler;
    logic            double_fault;

    modport master (
        output exc, estatus, eret, pc_exc, ext_irq,
        input  irq_to_ctrl, exc_ack, ext_iack, flush, pc_sel_vec, pc_sel_elr,
               vec_addr, elr_q, esr_q, in_handler, double_fault
    );

    modport slave (
        input  exc, estatus, eret, pc_exc, ext_irq,
        output irq_to_ctrl, exc_ack, ext_iack, flush, pc_sel_vec, pc_sel_elr,
               vec_addr, elr_q, esr_q, in_handler, double_fault
    );

endinterface

// File: rtl/irq_handshake.sv
// Interrupt pending latch and four-phase acknowledge towards the device.
module irq_handshake (
    input  logic clk,
    input  logic reset,
    input  logic ext_irq,
    input  logic iack_set,
    input  logic iack_clr,
    input  logic pend_clr,
    output logic irq_pend,
    output logic ext_iack
);

    // ack rises only against a high request and falls only against a low one
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_pend <= 1'b0;
            ext_iack <= 1'b0;
        end else begin
            if (pend_clr)
                irq_pend <= 1'b0;
            else if (ext_irq && !ext_iack)
                irq_pend <= 1'b1;

            if (iack_set && ext_irq)
                ext_iack <= 1'b1;
            else if (iack_clr && !ext_irq)
                ext_iack <= 1'b0;
        end
    end

endmodule

// File: rtl/exc_sequencer.sv
// Exception/interrupt sequencer: flush, vector, handler residency, return.
//   state      | meaning
//   IDLE       | normal execution, accept exc, offer qualified IRQ
//   FLUSH      | kill IF/ID/EX
//   VECTOR     | redirect PC to vector, ack controller (and device for IRQ)
//   HANDLER    | handler running, further exc flags double fault
//   RETURN     | redirect PC to ELR, flush, re-enable interrupts
//   IACK_WAIT  | hold device ack until request drops
module exc_sequencer
    import exc_pkg::*;
#(
    parameter int           N          = 64,
    parameter logic [N-1:0] VEC_ADDR   = N'(VEC_ADDR_DFLT),
    parameter bit           IRQ_EN_RST = 1'b1
) (
    input logic             clk,
    input logic             reset,
    exc_sequencer_if.slave  bus
);

    exc_state_t      state, state_nxt;
    logic [N-1:0]    elr;
    logic [ES_W-1:0] esr;
    logic            irq_en;
    logic            dfault;
    logic            irq_pend;
    logic            ext_iack;

    logic            flush, pc_sel_vec, pc_sel_elr, exc_ack, in_handler;
    logic            vector_irq;

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        flush      = 1'b0;
        pc_sel_vec = 1'b0;
        pc_sel_elr = 1'b0;
        exc_ack    = 1'b0;
        in_handler = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.exc)
                    state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                flush     = 1'b1;
                state_nxt = ST_VECTOR;
            end
            ST_VECTOR: begin
                pc_sel_vec = 1'b1;
                exc_ack    = 1'b1;
                state_nxt  = ST_HANDLER;
            end
            ST_HANDLER: begin
                in_handler = 1'b1;
                if (bus.eret)
                    state_nxt = ST_RETURN;
            end
            ST_RETURN: begin
                pc_sel_elr = 1'b1;
                flush      = 1'b1;
                state_nxt  = ext_iack ? ST_IACK_WAIT : ST_IDLE;
            end
            ST_IACK_WAIT: begin
                if (!bus.ext_irq)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            elr    <= '0;
            esr    <= ES_NONE;
            irq_en <= IRQ_EN_RST;
            dfault <= 1'b0;
        end else begin
            if (state == ST_IDLE && bus.exc) begin
                elr    <= bus.pc_exc;
                esr    <= bus.estatus;
                irq_en <= 1'b0;
            end
            if (state == ST_RETURN)
                irq_en <= 1'b1;
            if (state == ST_HANDLER && bus.exc)
                dfault <= 1'b1;
        end
    end

    // ack is registered on the FLUSH->VECTOR edge so the device sees it in VECTOR
    assign vector_irq = (state == ST_FLUSH) && (esr == ES_EXTIRQ);

    irq_handshake u_irq_handshake (
        .clk      (clk),
        .reset    (reset),
        .ext_irq  (bus.ext_irq),
        .iack_set (vector_irq),
        .iack_clr (state == ST_IACK_WAIT),
        .pend_clr (vector_irq),
        .irq_pend (irq_pend),
        .ext_iack (ext_iack)
    );

    assign bus.irq_to_ctrl  = irq_pend && irq_en && (state == ST_IDLE);
    assign bus.exc_ack      = exc_ack;
    assign bus.ext_iack     = ext_iack;
    assign bus.flush        = flush;
    assign bus.pc_sel_vec   = pc_sel_vec;
    assign bus.pc_sel_elr   = pc_sel_elr;
    assign bus.vec_addr     = VEC_ADDR;
    assign bus.elr_q        = elr;
    assign bus.esr_q        = esr;
    assign bus.in_handler   = in_handler;
    assign bus.double_fault = dfault;

endmodule
